// File: rtl/usb_pio_pkg.sv
// usb_pio_pkg: register offsets and edge-select encodings shared by the USB PIO slaves
package usb_pio_pkg;
    typedef logic [1:0] reg_addr_t;
    localparam reg_addr_t ADDR_DATA    = 2'd0;
    localparam reg_addr_t ADDR_RSVD    = 2'd1;
    localparam reg_addr_t ADDR_IRQMASK = 2'd2;
    localparam reg_addr_t ADDR_EDGECAP = 2'd3;
    localparam int EDGE_RISE = 0;
    localparam int EDGE_FALL = 1;
    localparam int EDGE_ANY  = 2;
endpackage

// File: rtl/usb_irq_pio_in_if.sv
// usb_irq_pio_in_if: Avalon-MM slave bus plus interrupt line of the input PIO
interface usb_irq_pio_in_if;
    import usb_pio_pkg::*;
    reg_addr_t   address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        irq;
    modport master (output address, chipselect, write_n, writedata, input readdata, irq);
    modport slave  (input address, chipselect, write_n, writedata, output readdata, irq);
endinterface

// File: rtl/pio_in_sync_debounce.sv
// pio_in_sync_debounce: one pin through a 2-flop synchronizer and a persistence filter, with edge pulses
module pio_in_sync_debounce #(
    parameter int DEBOUNCE_CYCLES = 1
) (
    input  logic clk,
    input  logic reset_n,
    input  logic pin,
    output logic deb,
    output logic rise,
    output logic fall
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);
    logic s1, s2, accept;
    logic [CW-1:0] cnt;
    assign accept = (s2 != deb) && (cnt == LAST);
    assign rise = accept & s2;
    assign fall = accept & ~s2;
    // sync the pin, count how long the synced value has differed from deb, accept it on the last count
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1  <= 1'b0;
            s2  <= 1'b0;
            deb <= 1'b0;
            cnt <= '0;
        end else begin
            s1 <= pin;
            s2 <= s1;
            if (s2 == deb) cnt <= '0;
            else if (cnt == LAST) begin
                deb <= s2;
                cnt <= '0;
            end else cnt <= cnt + 1'b1;
        end
    end
endmodule

// File: rtl/usb_irq_pio_in.sv
// usb_irq_pio_in: Avalon-MM input PIO sampling USB controller status pins, W1C edge capture, maskable irq
module usb_irq_pio_in
    import usb_pio_pkg::*;
#(
    parameter int WIDTH           = 4,
    parameter int DEBOUNCE_CYCLES = 1,
    parameter int EDGE_TYPE       = EDGE_RISE
) (
    input logic             clk,
    input logic             reset_n,
    usb_irq_pio_in_if.slave bus,
    input logic [WIDTH-1:0] in_port
);
    logic [WIDTH-1:0] deb, rise, fall, edge_sel, irqmask, edgecap, edgecap_next, clr;
    logic wr, irq, unused_wd;

    for (genvar i = 0; i < WIDTH; i++) begin : g_pin
        pio_in_sync_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_pin (
            .clk    (clk),
            .reset_n(reset_n),
            .pin    (in_port[i]),
            .deb    (deb[i]),
            .rise   (rise[i]),
            .fall   (fall[i])
        );
    end

    assign wr        = bus.chipselect && !bus.write_n;
    assign unused_wd = ^bus.writedata;
    assign bus.irq   = irq;

    // pick the captured edge type, and let a same-cycle edge win over a software clear
    always_comb begin
        edge_sel     = EDGE_TYPE == EDGE_ANY ? (rise | fall) : EDGE_TYPE == EDGE_FALL ? fall : rise;
        clr          = (wr && bus.address == ADDR_EDGECAP) ? bus.writedata[WIDTH-1:0] : '0;
        edgecap_next = (edgecap & ~clr) | edge_sel;
    end

    // zero-wait-state read mux, no side effects
    always_comb
        bus.readdata = bus.address == ADDR_DATA    ? 32'(deb)     :
                       bus.address == ADDR_IRQMASK ? 32'(irqmask) :
                       bus.address == ADDR_EDGECAP ? 32'(edgecap) :
                       bus.address == ADDR_RSVD    ? 32'h0        : 32'h0;

    // mask and capture registers; irq trails the visible capture/mask state by one cycle
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            irqmask <= '0;
            edgecap <= '0;
            irq     <= 1'b0;
        end else begin
            if (wr && bus.address == ADDR_IRQMASK) irqmask <= bus.writedata[WIDTH-1:0];
            edgecap <= edgecap_next;
            irq     <= |(edgecap & irqmask);
        end
    end
endmodule

// File: tb/tb_usb_irq_pio_in.sv
// tb_usb_irq_pio_in: three PIO configurations on one shared bus, checked against a pin-history model
module tb_usb_irq_pio_in;
    import usb_pio_pkg::*;
    localparam int NDUT = 3;
    localparam int DC [NDUT] = '{1, 8, 1};
    localparam int ET [NDUT] = '{EDGE_RISE, EDGE_RISE, EDGE_FALL};

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic [1:0] address = '0;
    logic cs = 1'b0;
    logic write_n = 1'b1;
    logic [31:0] writedata = '0;
    logic [3:0] in_port = '0;
    logic [31:0] rd [NDUT];
    logic irq_o [NDUT];
    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        usb_irq_pio_in_if bus ();
        assign bus.address    = address;
        assign bus.chipselect = cs;
        assign bus.write_n    = write_n;
        assign bus.writedata  = writedata;
        assign rd[g]          = bus.readdata;
        assign irq_o[g]       = bus.irq;
        usb_irq_pio_in #(.WIDTH(4), .DEBOUNCE_CYCLES(DC[g]), .EDGE_TYPE(ET[g])) dut (
            .clk    (clk),
            .reset_n(reset_n),
            .bus    (bus),
            .in_port(in_port)
        );
    end

    // reference model: a pin is accepted once its synchronized value has disagreed with
    // the accepted value over the whole last DEBOUNCE_CYCLES samples of pin history
    logic [3:0] h [10];
    logic [3:0] m_deb [NDUT], m_mask [NDUT], m_cap [NDUT], acc [NDUT], sel [NDUT], n_cap [NDUT], n_mask [NDUT];
    logic m_irq [NDUT];
    logic wr_now;
    assign wr_now = cs && !write_n;

    always_comb begin
        for (int k = 0; k < NDUT; k++) begin
            for (int b = 0; b < 4; b++) begin
                acc[k][b] = 1'b1;
                for (int j = 0; j < 8; j++)
                    if (j < DC[k] && h[1+j][b] == m_deb[k][b]) acc[k][b] = 1'b0;
            end
            sel[k] = ET[k] == EDGE_RISE ? acc[k] & ~m_deb[k] : ET[k] == EDGE_FALL ? acc[k] & m_deb[k] : acc[k];
            n_cap[k] = (m_cap[k] & ~((wr_now && address == ADDR_EDGECAP) ? writedata[3:0] : 4'h0)) | sel[k];
            n_mask[k] = (wr_now && address == ADDR_IRQMASK) ? writedata[3:0] : m_mask[k];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < NDUT; k++) begin
                m_deb[k]  <= '0;
                m_mask[k] <= '0;
                m_cap[k]  <= '0;
                m_irq[k]  <= 1'b0;
            end
            for (int j = 0; j < 10; j++) h[j] <= '0;
        end else begin
            for (int k = 0; k < NDUT; k++) begin
                m_deb[k]  <= m_deb[k] ^ acc[k];
                m_mask[k] <= n_mask[k];
                m_cap[k]  <= n_cap[k];
                m_irq[k]  <= |(m_cap[k] & m_mask[k]);
            end
            h[0] <= in_port;
            for (int j = 1; j < 10; j++) h[j] <= h[j-1];
        end
    end

    function automatic logic [31:0] exp_rd(int k, logic [1:0] a);
        return a == ADDR_DATA    ? {28'h0, m_deb[k]}  :
               a == ADDR_IRQMASK ? {28'h0, m_mask[k]} :
               a == ADDR_EDGECAP ? {28'h0, m_cap[k]}  : 32'h0;
    endfunction

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic wr(logic [1:0] a, logic [31:0] d);
        address = a; writedata = d; cs = 1'b1; write_n = 1'b0;
        tick();
        cs = 1'b0; write_n = 1'b1;
    endtask

    task automatic settle(logic [3:0] p);
        in_port = p;
        repeat (12) tick();
        wr(ADDR_EDGECAP, 32'hF);
    endtask

    task automatic test_reset();
        logic [31:0] want_data [NDUT] = '{32'hF, 32'h0, 32'hF};
        logic [31:0] want_cap [NDUT]  = '{32'hF, 32'h0, 32'h0};
        reset_n = 1'b0; in_port = 4'hF;
        repeat (3) tick();
        for (int a = 0; a < 4; a++) begin
            address = 2'(a); #1;
            for (int k = 0; k < NDUT; k++) begin
                n_cmp++; if (rd[k] !== 32'h0) begin n_bad++; $display("FAIL reset_rd dut%0d addr%0d: got %h want 0", k, a, rd[k]); end
            end
        end
        for (int k = 0; k < NDUT; k++) begin
            n_cmp++; if (irq_o[k] !== 1'b0) begin n_bad++; $display("FAIL reset_irq dut%0d: got %b want 0", k, irq_o[k]); end
        end
        address = ADDR_DATA;
        @(negedge clk); reset_n = 1'b1;
        repeat (3) tick();
        for (int k = 0; k < NDUT; k++) begin
            n_cmp++; if (rd[k] !== want_data[k]) begin n_bad++; $display("FAIL post_reset_data dut%0d: got %h want %h", k, rd[k], want_data[k]); end
        end
        address = ADDR_EDGECAP; #1;
        for (int k = 0; k < NDUT; k++) begin
            n_cmp++; if (rd[k] !== want_cap[k]) begin n_bad++; $display("FAIL post_reset_cap dut%0d: got %h want %h", k, rd[k], want_cap[k]); end
        end
        repeat (8) tick();
        n_cmp++; if (rd[1] !== 32'hF) begin n_bad++; $display("FAIL post_reset_cap_slow: got %h want f", rd[1]); end
    endtask

    task automatic test_rise_irq();
        settle(4'h0);
        wr(ADDR_IRQMASK, 32'h1);
        in_port = 4'h1; address = ADDR_DATA;
        repeat (2) tick();
        n_cmp++; if (rd[0] !== 32'h0) begin n_bad++; $display("FAIL rise_early: got %h want 0", rd[0]); end
        tick();
        n_cmp++; if (rd[0] !== 32'h1) begin n_bad++; $display("FAIL rise_data: got %h want 1", rd[0]); end
        address = ADDR_EDGECAP; #1;
        n_cmp++; if (rd[0] !== 32'h1) begin n_bad++; $display("FAIL rise_cap: got %h want 1", rd[0]); end
        n_cmp++; if (irq_o[0] !== 1'b0) begin n_bad++; $display("FAIL irq_lag: got %b want 0", irq_o[0]); end
        tick();
        n_cmp++; if (irq_o[0] !== 1'b1) begin n_bad++; $display("FAIL irq_set: got %b want 1", irq_o[0]); end
        wr(ADDR_EDGECAP, 32'h1);
        n_cmp++; if (rd[0] !== 32'h0) begin n_bad++; $display("FAIL w1c_cap: got %h want 0", rd[0]); end
        n_cmp++; if (irq_o[0] !== 1'b1) begin n_bad++; $display("FAIL irq_hold: got %b want 1", irq_o[0]); end
        tick();
        n_cmp++; if (irq_o[0] !== 1'b0) begin n_bad++; $display("FAIL irq_clear: got %b want 0", irq_o[0]); end
    endtask

    task automatic test_debounce();
        settle(4'h0);
        address = ADDR_DATA;
        in_port = 4'h2;
        repeat (5) tick();
        in_port = 4'h0;
        repeat (12) begin
            tick();
            n_cmp++; if (rd[1] !== 32'h0) begin n_bad++; $display("FAIL glitch_data: got %h want 0", rd[1]); end
        end
        address = ADDR_EDGECAP; #1;
        n_cmp++; if (rd[1] !== 32'h0) begin n_bad++; $display("FAIL glitch_cap: got %h want 0", rd[1]); end
        address = ADDR_DATA; in_port = 4'h2;
        for (int i = 1; i <= 10; i++) begin
            tick();
            n_cmp++; if (rd[1][1] !== (i == 10)) begin n_bad++; $display("FAIL deb_latency tick%0d: got %b want %b", i, rd[1][1], i == 10); end
        end
        repeat (10) tick();
        address = ADDR_EDGECAP; #1;
        n_cmp++; if (rd[1] !== 32'h2) begin n_bad++; $display("FAIL deb_cap: got %h want 2", rd[1]); end
    endtask

    task automatic test_simul_clear();
        settle(4'h0);
        wr(ADDR_IRQMASK, 32'h4);
        in_port = 4'h5;
        repeat (3) tick();
        address = ADDR_EDGECAP; #1;
        n_cmp++; if (rd[0] !== 32'h5) begin n_bad++; $display("FAIL sc_pre: got %h want 5", rd[0]); end
        in_port = 4'h0;
        repeat (4) tick();
        n_cmp++; if (irq_o[0] !== 1'b1) begin n_bad++; $display("FAIL sc_irq_pre: got %b want 1", irq_o[0]); end
        in_port = 4'h4;
        repeat (2) tick();
        address = ADDR_EDGECAP; writedata = 32'hF; cs = 1'b1; write_n = 1'b0;
        tick();
        cs = 1'b0; write_n = 1'b1;
        n_cmp++; if (rd[0] !== 32'h4) begin n_bad++; $display("FAIL sc_set_wins: got %h want 4", rd[0]); end
        tick();
        n_cmp++; if (irq_o[0] !== 1'b1) begin n_bad++; $display("FAIL sc_irq_keep: got %b want 1", irq_o[0]); end
    endtask

    task automatic test_fall();
        settle(4'hF);
        wr(ADDR_IRQMASK, 32'h0);
        in_port = 4'h7;
        repeat (3) tick();
        address = ADDR_EDGECAP; #1;
        n_cmp++; if (rd[2] !== 32'h8) begin n_bad++; $display("FAIL fall_cap: got %h want 8", rd[2]); end
        n_cmp++; if (rd[0] !== 32'h0) begin n_bad++; $display("FAIL rise_ignores_fall: got %h want 0", rd[0]); end
        repeat (2) tick();
        n_cmp++; if (irq_o[2] !== 1'b0) begin n_bad++; $display("FAIL fall_irq_masked: got %b want 0", irq_o[2]); end
        in_port = 4'hF;
        repeat (4) tick();
        n_cmp++; if (rd[2] !== 32'h8) begin n_bad++; $display("FAIL fall_no_rise: got %h want 8", rd[2]); end
        n_cmp++; if (rd[0] !== 32'h8) begin n_bad++; $display("FAIL rise_after_fall: got %h want 8", rd[0]); end
        n_cmp++; if (irq_o[2] !== 1'b0) begin n_bad++; $display("FAIL fall_irq_idle: got %b want 0", irq_o[2]); end
    endtask

    task automatic test_reset_mid();
        settle(4'h0);
        wr(ADDR_IRQMASK, 32'hF);
        address = ADDR_DATA; in_port = 4'h2;
        repeat (6) tick();
        n_cmp++; if (irq_o[0] !== 1'b1) begin n_bad++; $display("FAIL rm_pre_irq: got %b want 1", irq_o[0]); end
        #1 reset_n = 1'b0;
        for (int a = 0; a < 4; a++) begin
            address = 2'(a); #1;
            for (int k = 0; k < NDUT; k++) begin
                n_cmp++; if (rd[k] !== 32'h0) begin n_bad++; $display("FAIL rm_rd dut%0d addr%0d: got %h want 0", k, a, rd[k]); end
            end
        end
        for (int k = 0; k < NDUT; k++) begin
            n_cmp++; if (irq_o[k] !== 1'b0) begin n_bad++; $display("FAIL rm_irq dut%0d: got %b want 0", k, irq_o[k]); end
        end
        address = ADDR_DATA;
        @(negedge clk); reset_n = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            tick();
            n_cmp++; if (rd[1][1] !== (i == 10)) begin n_bad++; $display("FAIL rm_restart tick%0d: got %b want %b", i, rd[1][1], i == 10); end
        end
        address = ADDR_EDGECAP; #1;
        n_cmp++; if (rd[1] !== 32'h2) begin n_bad++; $display("FAIL rm_cap: got %h want 2", rd[1]); end
    endtask

    task automatic test_random();
        for (int c = 0; c < 800; c++) begin
            if ($urandom_range(11) == 0) in_port = 4'($urandom);
            address   = 2'($urandom);
            writedata = $urandom;
            cs        = ($urandom_range(2) == 0);
            write_n   = ($urandom_range(2) != 0);
            tick();
            for (int k = 0; k < NDUT; k++) begin
                n_cmp++; if (rd[k] !== exp_rd(k, address)) begin n_bad++; $display("FAIL rand_rd dut%0d cyc%0d addr%0d: got %h want %h", k, c, address, rd[k], exp_rd(k, address)); end
                n_cmp++; if (irq_o[k] !== m_irq[k]) begin n_bad++; $display("FAIL rand_irq dut%0d cyc%0d: got %b want %b", k, c, irq_o[k], m_irq[k]); end
            end
        end
        cs = 1'b0; write_n = 1'b1;
    endtask

    initial begin
        test_reset();
        test_rise_irq();
        test_debounce();
        test_simul_clear();
        test_fall();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
